cal_abs_angle_arbiter: RTL and testbench

Round-robin arbiter that shares a single `CalAbsAngle` magnitude/angle core between `NUM_CH` sample requesters. It sits in front of the core and accepts at most one complex sample per cycle through a valid/ready handshake. It tags each issued sample with its channel ID in an in-order tag FIFO and returns each core result to the requester that issued it. Because the core has no backpressure, the tag FIFO depth sets the maximum number of samples in flight.

---
 rtl/cal_abs_angle_pkg.sv | 14 +
 rtl/tag_fifo.sv | 79 +++++++
 rtl/cal_abs_angle_arbiter.sv | 154 +++++++++++++++
 tb/tb_cal_abs_angle_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cal_abs_angle_pkg.sv
// rtl/cal_abs_angle_pkg.sv - shared widths and channel-id type for the CalAbsAngle arbiter
// Holds the default data/angle widths and the requester count that the
// arbiter, the core wrapper and the bench agree on.
package cal_abs_angle_pkg;

    localparam int NUM_CH_DEF    = 4;
    localparam int TAG_DEPTH_DEF = 16;
    localparam int DW_DEF        = 8;
    localparam int AW_DEF        = 16;
    localparam int CHW_DEF       = $clog2(NUM_CH_DEF);

    typedef logic [CHW_DEF-1:0] chan_id_t;

endpackage

// File: rtl/tag_fifo.sv
// rtl/tag_fifo.sv - in-order channel tag FIFO with occupancy count
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   push_i/push_data_i  write a tag (ignored when full)
//   pop_i           drop the head tag (ignored when empty)
//   pop_data_o      current head tag
//   count_o         occupancy 0..DEPTH
//   full_o/empty_o  occupancy flags
module tag_fifo #(
    parameter int W     = 2,
    parameter int DEPTH = 16,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [W-1:0]  push_data_i,
    input  logic          pop_i,
    output logic [W-1:0]  pop_data_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full_o     = (count_q == CW'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign pop_data_o = mem_q[rd_ptr_q];

    // Fullness is judged on the pre-pop occupancy, so a full FIFO refuses a
    // push even when the same cycle pops.
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Tag storage needs no reset: the pointers and count define validity.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/cal_abs_angle_arbiter.sv
// rtl/cal_abs_angle_arbiter.sv - round-robin sharing of one CalAbsAngle core between requesters
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   ch_en_i, req_val_i             per-channel enable mask and sample valid
//   req_real_i, req_imag_i         flattened samples, channel k at [k*DW +: DW]
//   req_rdy_o                      one-hot grant (zero when nothing may issue)
//   core_real_o/imag_o/val_o       registered sample towards the core
//   core_abs_i/angle_i/val_i       core result (no backpressure)
//   res_val_o/ch_o/abs_o/angle_o   registered result tagged with its channel
//   inflight_o                     tag FIFO occupancy
//   err_o                          sticky: core result arrived with no tag
module cal_abs_angle_arbiter
    import cal_abs_angle_pkg::*;
#(
    parameter int NUM_CH    = NUM_CH_DEF,
    parameter int TAG_DEPTH = TAG_DEPTH_DEF,
    parameter int DW        = DW_DEF,
    parameter int AW        = AW_DEF,
    localparam int CHW      = $clog2(NUM_CH),
    localparam int CNTW     = $clog2(TAG_DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_CH-1:0]    ch_en_i,
    input  logic [NUM_CH-1:0]    req_val_i,
    input  logic [NUM_CH*DW-1:0] req_real_i,
    input  logic [NUM_CH*DW-1:0] req_imag_i,
    output logic [NUM_CH-1:0]    req_rdy_o,
    output logic [DW-1:0]      core_real_o,
    output logic [DW-1:0]      core_imag_o,
    output logic               core_val_o,
    input  logic [DW-1:0]      core_abs_i,
    input  logic [AW-1:0]      core_angle_i,
    input  logic               core_val_i,
    output logic               res_val_o,
    output logic [CHW-1:0]     res_ch_o,
    output logic [DW-1:0]      res_abs_o,
    output logic [AW-1:0]      res_angle_o,
    output logic [CNTW-1:0]    inflight_o,
    output logic               err_o
);

    logic [CHW-1:0] rr_ptr_q, rr_ptr_d;
    logic [DW-1:0]  core_real_q, core_real_d;
    logic [DW-1:0]  core_imag_q, core_imag_d;
    logic           core_val_q, core_val_d;
    logic           res_val_q, res_val_d;
    logic [CHW-1:0] res_ch_q, res_ch_d;
    logic [DW-1:0]  res_abs_q, res_abs_d;
    logic [AW-1:0]  res_angle_q, res_angle_d;
    logic           err_q, err_d;

    logic [NUM_CH-1:0] elig;
    logic              found;
    logic [CHW-1:0]    win;
    int                scan_idx;
    logic              grant_ok;
    logic              pop;
    logic [CHW-1:0]    head_tag;
    logic              fifo_full, fifo_empty;

    assign elig = req_val_i & ch_en_i;

    // Scan from the round-robin pointer upward, wrapping at NUM_CH; the first
    // eligible channel wins.
    always_comb begin
        found    = 1'b0;
        win      = '0;
        scan_idx = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            scan_idx = (int'(rr_ptr_q) + i) % NUM_CH;
            if (!found && elig[scan_idx]) begin
                found = 1'b1;
                win   = CHW'(scan_idx);
            end
        end
    end

    // rst_n gates the grant so nothing handshakes while reset is asserted.
    assign grant_ok  = found & ~fifo_full & rst_n;
    assign req_rdy_o = grant_ok ? (NUM_CH'(1) << win) : '0;
    assign pop       = core_val_i & ~fifo_empty;

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        core_val_d  = grant_ok;
        core_real_d = core_real_q;
        core_imag_d = core_imag_q;
        res_val_d   = pop;
        res_ch_d    = res_ch_q;
        res_abs_d   = res_abs_q;
        res_angle_d = res_angle_q;
        err_d       = err_q | (core_val_i & fifo_empty);
        if (grant_ok) begin
            rr_ptr_d    = (win == CHW'(NUM_CH - 1)) ? '0 : win + CHW'(1);
            core_real_d = req_real_i[int'(win)*DW +: DW];
            core_imag_d = req_imag_i[int'(win)*DW +: DW];
        end
        if (pop) begin
            res_ch_d    = head_tag;
            res_abs_d   = core_abs_i;
            res_angle_d = core_angle_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            core_val_q  <= 1'b0;
            core_real_q <= '0;
            core_imag_q <= '0;
            res_val_q   <= 1'b0;
            res_ch_q    <= '0;
            res_abs_q   <= '0;
            res_angle_q <= '0;
            err_q       <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            core_val_q  <= core_val_d;
            core_real_q <= core_real_d;
            core_imag_q <= core_imag_d;
            res_val_q   <= res_val_d;
            res_ch_q    <= res_ch_d;
            res_abs_q   <= res_abs_d;
            res_angle_q <= res_angle_d;
            err_q       <= err_d;
        end
    end

    tag_fifo #(
        .W     (CHW),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (grant_ok),
        .push_data_i (win),
        .pop_i       (pop),
        .pop_data_o  (head_tag),
        .count_o     (inflight_o),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign core_val_o  = core_val_q;
    assign core_real_o = core_real_q;
    assign core_imag_o = core_imag_q;
    assign res_val_o   = res_val_q;
    assign res_ch_o    = res_ch_q;
    assign res_abs_o   = res_abs_q;
    assign res_angle_o = res_angle_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_cal_abs_angle_arbiter.sv
// tb/tb_cal_abs_angle_arbiter.sv - randomized bench with queue reference model and stub core
module tb_cal_abs_angle_arbiter;
    import cal_abs_angle_pkg::*;

    localparam int NCH = 4;
    localparam int TD  = 8;
    localparam int DW  = 8;
    localparam int AW  = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic [NCH-1:0]    ch_en_i, req_val_i, req_rdy_o;
    logic [NCH*DW-1:0] req_real_i, req_imag_i;
    logic [DW-1:0]   core_real_o, core_imag_o, core_abs_i, res_abs_o;
    logic            core_val_o, core_val_i, res_val_o, err_o;
    logic [AW-1:0]   core_angle_i, res_angle_o;
    chan_id_t        res_ch_o;
    logic [3:0]      inflight_o;

    cal_abs_angle_arbiter #(.NUM_CH(NCH), .TAG_DEPTH(TD), .DW(DW), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .ch_en_i(ch_en_i), .req_val_i(req_val_i),
        .req_real_i(req_real_i), .req_imag_i(req_imag_i), .req_rdy_o(req_rdy_o),
        .core_real_o(core_real_o), .core_imag_o(core_imag_o), .core_val_o(core_val_o),
        .core_abs_i(core_abs_i), .core_angle_i(core_angle_i), .core_val_i(core_val_i),
        .res_val_o(res_val_o), .res_ch_o(res_ch_o), .res_abs_o(res_abs_o),
        .res_angle_o(res_angle_o), .inflight_o(inflight_o), .err_o(err_o)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] mag(input logic [DW-1:0] r, input logic [DW-1:0] i);
        int s, q;
        s = int'(r) * int'(r) + int'(i) * int'(i);
        q = 0;
        while ((q + 1) * (q + 1) <= s) q++;
        return DW'(q);
    endfunction

    // Stub core: replays what the arbiter issued `lat` cycles earlier.
    int lat = 6;
    int cyc = 0;
    logic          hv [64];
    logic [DW-1:0] hr [64];
    logic [DW-1:0] hi [64];

    task automatic set_lat(input int l);
        lat = l;
        for (int k = 0; k < 64; k++) hv[k] = 1'b0;
    endtask

    // Reference model: a queue of expected results plus a priority pointer.
    typedef struct packed {
        chan_id_t      ch;
        logic [DW-1:0] abs_v;
        logic [AW-1:0] ang;
    } exp_t;
    exp_t   mq[$];
    int     m_rr = 0;
    int     m_grant;
    logic   e_core_val = 0, e_res_val = 0, e_err = 0;
    logic [DW-1:0] e_core_real = 0, e_core_imag = 0, e_res_abs = 0;
    logic [AW-1:0] e_res_ang = 0;
    chan_id_t      e_res_ch = 0;
    logic          fix34 = 0;
    logic [DW-1:0] dr [NCH];
    logic [DW-1:0] di [NCH];

    task automatic run_cycle(input logic rst, input logic [NCH-1:0] val,
                             input logic [NCH-1:0] en, input logic inj);
        logic [NCH-1:0] e_rdy;
        logic           stub_v;
        int             slot;
        @(negedge clk);
        hv[cyc % 64] = core_val_o;
        hr[cyc % 64] = core_real_o;
        hi[cyc % 64] = core_imag_o;
        slot   = (cyc - lat + 64) % 64;
        stub_v = (cyc >= lat) ? hv[slot] : 1'b0;
        core_val_i   = stub_v | inj;
        core_abs_i   = mag(hr[slot], hi[slot]);
        core_angle_i = {hi[slot], hr[slot]};
        rst_n     = ~rst;
        ch_en_i   = en;
        req_val_i = val;
        for (int k = 0; k < NCH; k++) begin
            dr[k] = fix34 ? 8'h03 : DW'($urandom);
            di[k] = fix34 ? 8'h04 : DW'($urandom);
            req_real_i[k*DW +: DW] = dr[k];
            req_imag_i[k*DW +: DW] = di[k];
        end
        #1;
        m_grant = -1;
        if (!rst && mq.size() < TD) begin
            for (int k = 0; k < NCH; k++) begin
                int c;
                c = (m_rr + k) % NCH;
                if (m_grant < 0 && val[c] && en[c]) m_grant = c;
            end
        end
        e_rdy = '0;
        if (m_grant >= 0) e_rdy[m_grant] = 1'b1;
        check_eq("req_rdy", req_rdy_o, e_rdy);
        check_eq("core_val", core_val_o, e_core_val);
        check_eq("core_real", core_real_o, e_core_real);
        check_eq("core_imag", core_imag_o, e_core_imag);
        check_eq("res_val", res_val_o, e_res_val);
        check_eq("res_ch", res_ch_o, e_res_ch);
        check_eq("res_abs", res_abs_o, e_res_abs);
        check_eq("res_angle", res_angle_o, e_res_ang);
        check_eq("inflight", inflight_o, mq.size());
        check_eq("err", err_o, e_err);
        if (rst) begin
            mq.delete();
            m_rr = 0;
            e_core_val = 0; e_core_real = 0; e_core_imag = 0;
            e_res_val = 0; e_res_ch = 0; e_res_abs = 0; e_res_ang = 0;
            e_err = 0;
        end else begin
            e_res_val = 1'b0;
            if (core_val_i) begin
                if (mq.size() > 0) begin
                    exp_t x;
                    x = mq.pop_front();
                    e_res_val = 1'b1;
                    e_res_ch  = x.ch;
                    e_res_abs = x.abs_v;
                    e_res_ang = x.ang;
                end else begin
                    e_err = 1'b1;
                end
            end
            e_core_val = (m_grant >= 0);
            if (m_grant >= 0) begin
                mq.push_back({chan_id_t'(m_grant), mag(dr[m_grant], di[m_grant]),
                              di[m_grant], dr[m_grant]});
                e_core_real = dr[m_grant];
                e_core_imag = di[m_grant];
                m_rr = (m_grant + 1) % NCH;
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) run_cycle(1'b0, '0, '1, 1'b0);
    endtask

    int  sent, first_acc, first_res, n_res;
    int  gcnt [NCH];
    logic saw_stall;

    initial begin
        rst_n = 1'b0; ch_en_i = '0; req_val_i = '0; req_real_i = '0; req_imag_i = '0;
        core_val_i = 1'b0; core_abs_i = '0; core_angle_i = '0;
        for (int k = 0; k < 64; k++) begin hv[k] = 0; hr[k] = 0; hi[k] = 0; end
        repeat (2) @(posedge clk);

        // Single channel: ch 2, five 3+4j samples, core latency 6.
        set_lat(6);
        fix34 = 1; sent = 0; first_acc = -1; first_res = -1; n_res = 0;
        for (int t = 0; t < 30; t++) begin
            run_cycle(1'b0, (sent < 5) ? 4'b0100 : 4'b0000, 4'b0100, 1'b0);
            if (m_grant == 2) begin
                if (first_acc < 0) first_acc = cyc - 1;
                sent++;
            end
            if (res_val_o && res_ch_o == 2 && res_abs_o == 8'h05) begin
                n_res++;
                if (first_res < 0) first_res = cyc - 1;
            end
        end
        fix34 = 0;
        check_eq("single_res_count", n_res, 5);
        check_eq("single_latency", first_res - first_acc, 8);

        // Fairness after reset: four channels always valid for 40 cycles.
        set_lat(3);
        run_cycle(1'b1, '0, '1, 1'b0);
        for (int k = 0; k < NCH; k++) gcnt[k] = 0;
        for (int t = 0; t < 40; t++) begin
            run_cycle(1'b0, '1, '1, 1'b0);
            for (int k = 0; k < NCH; k++) if (req_rdy_o[k]) gcnt[k]++;
        end
        for (int k = 0; k < NCH; k++) check_eq($sformatf("fair_ch%0d", k), gcnt[k], 10);
        idle(10);

        // Back-pressure: latency 20 against an 8-deep tag FIFO.
        set_lat(20);
        saw_stall = 0;
        for (int t = 0; t < 60; t++) begin
            run_cycle(1'b0, '1, '1, 1'b0);
            if (inflight_o == 4'd8 && req_rdy_o == '0) saw_stall = 1;
        end
        check_eq("bp_stall_seen", saw_stall, 1'b1);
        idle(30);

        // Enable mask 1010: only channels 1 and 3, alternating.
        set_lat(2);
        for (int k = 0; k < NCH; k++) gcnt[k] = 0;
        for (int t = 0; t < 20; t++) begin
            run_cycle(1'b0, '1, 4'b1010, 1'b0);
            for (int k = 0; k < NCH; k++) if (req_rdy_o[k]) gcnt[k]++;
        end
        check_eq("mask_ch0", gcnt[0], 0);
        check_eq("mask_ch1", gcnt[1], 10);
        check_eq("mask_ch2", gcnt[2], 0);
        check_eq("mask_ch3", gcnt[3], 10);
        idle(8);

        // Spurious core result with nothing in flight.
        run_cycle(1'b0, '0, '1, 1'b1);
        idle(4);
        check_eq("spurious_err_sticky", err_o, 1'b1);

        // Reset with three samples in flight, then fresh traffic.
        run_cycle(1'b1, '0, '1, 1'b0);
        set_lat(6);
        for (int t = 0; t < 3; t++) run_cycle(1'b0, 4'b0001, '1, 1'b0);
        run_cycle(1'b1, '1, '1, 1'b0);
        check_eq("rst_inflight", inflight_o, 3);
        idle(1);
        check_eq("post_rst_inflight", inflight_o, 0);
        idle(12);
        check_eq("late_result_err", err_o, 1'b1);
        for (int t = 0; t < 40; t++)
            run_cycle(1'b0, NCH'($urandom), NCH'($urandom) | 4'b0001, 1'b0);
        idle(15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
